// File: rtl/pc_gen_ras_if.sv
// Fetch-stage control/observation bundle for pc_gen_ras.
// The pipeline side (master) drives redirect requests and observes the PC and RAS status.
interface pc_gen_ras_if #(
    parameter int unsigned WIDTH = 32
);
    logic             stall;
    logic             exc;
    logic             branch_taken;
    logic [WIDTH-1:0] branch_tgt;
    logic             jump;
    logic [WIDTH-1:0] jump_tgt;
    logic             call;
    logic             ret;
    logic [WIDTH-1:0] pc_out;
    logic [WIDTH-1:0] pc_next_seq;
    logic             ras_empty;
    logic             ras_full;
    logic             ret_miss;

    modport master (
        output stall, exc, branch_taken, branch_tgt, jump, jump_tgt, call, ret,
        input  pc_out, pc_next_seq, ras_empty, ras_full, ret_miss
    );

    modport slave (
        input  stall, exc, branch_taken, branch_tgt, jump, jump_tgt, call, ret,
        output pc_out, pc_next_seq, ras_empty, ras_full, ret_miss
    );
endinterface

// File: rtl/pc_gen_ras.sv
// Program-counter generator with prioritised next-PC selection and a circular
// return-address stack for predicting subroutine returns.
module pc_gen_ras #(
    parameter int unsigned       WIDTH       = 32,
    parameter int unsigned       INSTR_BYTES = 4,
    parameter logic [WIDTH-1:0]  RESET_VEC   = 32'h0000_0000,
    parameter logic [WIDTH-1:0]  EXC_VEC     = 32'h0000_0080,
    parameter int unsigned       RAS_DEPTH   = 8
) (
    input logic         clk,
    input logic         rst,
    pc_gen_ras_if.slave bus
);
    localparam int unsigned PTRW = $clog2(RAS_DEPTH);
    localparam int unsigned CNTW = PTRW + 1;

    localparam logic [WIDTH-1:0] INC        = WIDTH'(INSTR_BYTES);
    localparam logic [WIDTH-1:0] ALIGN_MASK = ~(INC - WIDTH'(1));
    localparam logic [PTRW-1:0]  PTR_ONE    = PTRW'(1);
    localparam logic [CNTW-1:0]  CNT_ONE    = CNTW'(1);
    localparam logic [CNTW-1:0]  CNT_FULL   = CNTW'(RAS_DEPTH);

    logic [WIDTH-1:0] pc_q, pc_d, seq;
    logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
    logic [PTRW-1:0]  top_q, top_inc;
    logic [CNTW-1:0]  count_q;
    logic             miss_q, miss_d;
    logic             push, pop, clr;

    assign seq     = pc_q + INC;
    assign top_inc = top_q + PTR_ONE;

    always_comb begin
        pc_d   = seq;
        push   = 1'b0;
        pop    = 1'b0;
        clr    = 1'b0;
        miss_d = 1'b0;
        if (bus.exc) begin
            pc_d = EXC_VEC;
            clr  = 1'b1;
        end else if (bus.branch_taken) begin
            pc_d = bus.branch_tgt & ALIGN_MASK;
        end else if (bus.stall) begin
            pc_d = pc_q;
        end else if (bus.jump) begin
            pc_d = bus.jump_tgt & ALIGN_MASK;
            push = bus.call;
        end else if (bus.ret) begin
            if (count_q != '0) begin
                pc_d = ras_mem[top_q] & ALIGN_MASK;
                pop  = 1'b1;
            end else begin
                miss_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q    <= RESET_VEC;
            top_q   <= '0;
            count_q <= '0;
            miss_q  <= 1'b0;
        end else begin
            pc_q   <= pc_d;
            miss_q <= miss_d;
            if (clr) begin
                top_q   <= '0;
                count_q <= '0;
            end else if (push) begin
                // Full stack: pointer keeps advancing, overwriting the oldest entry.
                top_q <= top_inc;
                if (count_q != CNT_FULL) count_q <= count_q + CNT_ONE;
            end else if (pop) begin
                top_q   <= top_q - PTR_ONE;
                count_q <= count_q - CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst && push) ras_mem[top_inc] <= seq;
    end

    assign bus.pc_out      = pc_q;
    assign bus.pc_next_seq = seq;
    assign bus.ras_empty   = (count_q == '0);
    assign bus.ras_full    = (count_q == CNT_FULL);
    assign bus.ret_miss    = miss_q;
endmodule
